// File: rtl/mc_cpu_core.sv
// Multi-cycle accumulator-style CPU core: FETCH/LATCH/EXEC/WB sequencing over an external
// synchronous-read instruction memory, with handshaked IN/OUT ports and a sticky halt.
module mc_cpu_core #(
    parameter int unsigned DW    = 8,
    parameter int unsigned IM_AW = 8,
    parameter int unsigned RF_AW = 4,
    parameter int unsigned OPW   = 4,
    parameter int unsigned IW    = OPW + 3 * RF_AW
) (
    input  logic             clk,
    input  logic             rst,
    output logic [IM_AW-1:0] imem_addr,
    input  logic [IW-1:0]    imem_data,
    input  logic [DW-1:0]    in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [DW-1:0]    out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             halted,
    output logic [IM_AW-1:0] pc
);

    localparam int unsigned NREG = 2 ** RF_AW;

    localparam logic [3:0] OpLoadi = 4'b0001;
    localparam logic [3:0] OpAnd   = 4'b0011;
    localparam logic [3:0] OpAdd   = 4'b0100;
    localparam logic [3:0] OpSub   = 4'b0101;
    localparam logic [3:0] OpOr    = 4'b0110;
    localparam logic [3:0] OpXor   = 4'b0111;
    localparam logic [3:0] OpBra   = 4'b1000;
    localparam logic [3:0] OpBraz  = 4'b1001;
    localparam logic [3:0] OpBral  = 4'b1010;
    localparam logic [3:0] OpBralz = 4'b1011;
    localparam logic [3:0] OpCall  = 4'b1100;
    localparam logic [3:0] OpIn    = 4'b1101;
    localparam logic [3:0] OpHalt  = 4'b1110;
    localparam logic [3:0] OpOut   = 4'b1111;

    typedef enum logic [2:0] {
        StFetch,
        StLatch,
        StExec,
        StWb,
        StOutWait,
        StHalt
    } state_e;

    state_e            state_q, state_d;
    logic [IM_AW-1:0]  pc_q, pc_d;
    logic [IW-1:0]     ir_q, ir_d;
    logic [DW-1:0]     w_q, w_d;
    logic [DW-1:0]     out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [DW-1:0]     rf_q [NREG];
    logic              rf_we;

    logic [3:0]        opcode;
    logic [RF_AW-1:0]  ra, rb, rd;
    logic [DW-1:0]     ra_val, rb_val;

    assign opcode = ir_q[IW-1 -: OPW];
    assign ra     = ir_q[IW-OPW-1 -: RF_AW];
    assign rb     = ir_q[IW-OPW-RF_AW-1 -: RF_AW];
    assign rd     = ir_q[RF_AW-1:0];
    assign ra_val = rf_q[ra];
    assign rb_val = rf_q[rb];

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign halted    = (state_q == StHalt);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        w_d         = w_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        rf_we       = 1'b0;
        in_ready    = 1'b0;

        unique case (state_q)
            StFetch: begin
                state_d = StLatch;
            end
            StLatch: begin
                ir_d    = imem_data;
                pc_d    = pc_q + IM_AW'(1);
                state_d = StExec;
            end
            StExec: begin
                state_d = StFetch;
                case (opcode)
                    OpLoadi: begin
                        w_d     = DW'({ra, rb});
                        state_d = StWb;
                    end
                    OpAnd: begin
                        w_d     = ra_val & rb_val;
                        state_d = StWb;
                    end
                    OpAdd: begin
                        w_d     = ra_val + rb_val;
                        state_d = StWb;
                    end
                    OpSub: begin
                        w_d     = ra_val - rb_val;
                        state_d = StWb;
                    end
                    OpOr: begin
                        w_d     = ra_val | rb_val;
                        state_d = StWb;
                    end
                    OpXor: begin
                        w_d     = ra_val ^ rb_val;
                        state_d = StWb;
                    end
                    OpBra: begin
                        pc_d = IM_AW'(rb_val);
                    end
                    OpBraz: begin
                        if (ra_val == '0) begin
                            pc_d = IM_AW'(rb_val);
                        end
                    end
                    OpBral: begin
                        pc_d = IM_AW'(rb);
                    end
                    OpBralz: begin
                        if (ra_val == '0) begin
                            pc_d = IM_AW'(rb);
                        end
                    end
                    OpCall: begin
                        // pc_q already points past the CALL, so this is the return address
                        w_d     = DW'(pc_q);
                        pc_d    = IM_AW'(rb);
                        state_d = StWb;
                    end
                    OpIn: begin
                        in_ready = 1'b1;
                        if (in_valid) begin
                            w_d     = in_data;
                            state_d = StWb;
                        end else begin
                            state_d = StExec;
                        end
                    end
                    OpHalt: begin
                        state_d = StHalt;
                    end
                    OpOut: begin
                        out_data_d  = ra_val;
                        out_valid_d = 1'b1;
                        state_d     = StOutWait;
                    end
                    default: begin
                        state_d = StFetch;
                    end
                endcase
            end
            StWb: begin
                rf_we   = 1'b1;
                state_d = StFetch;
            end
            StOutWait: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StFetch;
                end
            end
            StHalt: begin
                state_d = StHalt;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StFetch;
            pc_q        <= '0;
            ir_q        <= '0;
            w_q         <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            w_q         <= w_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            if (rf_we) begin
                rf_q[rd] <= w_q;
            end
        end
    end

endmodule

// File: tb/tb_mc_cpu_core.sv
// Program-level bench for mc_cpu_core: loads small programs into a synchronous imem model and
// scoreboards the OUT port against values pushed when each program is loaded.
module tb_mc_cpu_core;

    logic        clk;
    logic        rst;
    logic [7:0]  imem_addr;
    logic [15:0] imem_data;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        halted;
    logic [7:0]  pc;

    logic [15:0] imem [256];
    logic [7:0]  exp_q [$];

    int n_total = 0;
    int n_bad   = 0;
    int valid_cycles = 0;
    int in_hs = 0;
    int cyc;
    int n;

    bit         pend = 1'b0;
    logic [7:0] held = '0;

    mc_cpu_core dut (
        .clk       (clk),
        .rst       (rst),
        .imem_addr (imem_addr),
        .imem_data (imem_data),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .halted    (halted),
        .pc        (pc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) imem_data <= imem[imem_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [3:0] rd);
        return {op, ra, rb, rd};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 256; i++) imem[i] = 16'hE000;
    endtask

    // OUT-port scoreboard and hold checker, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (pend && !out_valid) check_eq("out_drop", 32'(out_valid), 1);
            if (out_valid) begin
                valid_cycles++;
                if (pend) check_eq("out_hold", 32'(out_data), 32'(held));
                held = out_data;
                pend = !out_ready;
                if (out_ready) begin
                    if (exp_q.size() == 0) check_eq("out_extra", exp_q.size(), 1);
                    else check_eq("out_data", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end else begin
                pend = 1'b0;
            end
            if (in_valid && in_ready) in_hs++;
        end
    end

    task automatic run_prog(output int cycles);
        cycles = 0;
        while (!halted && cycles < 2000) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        check_eq("halt_reached", 32'(halted), 1);
    endtask

    task automatic start_prog();
        valid_cycles = 0;
        in_hs = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic in_out_driver();
        int k = 0;
        do begin @(negedge clk); k++; end while (!in_ready && k < 100);
        check_eq("in_ready_seen", 32'(in_ready), 1);
        repeat (5) begin
            @(negedge clk);
            check_eq("in_ready_hold", 32'(in_ready), 1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        k = 0;
        do begin @(negedge clk); k++; end while (!out_valid && k < 100);
        check_eq("out_valid_seen", 32'(out_valid), 1);
        repeat (2) begin
            @(negedge clk);
            check_eq("out_wait", 32'({out_valid, out_data}), 32'({1'b1, 8'h5A}));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
    endtask

    initial begin
        logic [7:0] a, b;
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        clear_mem();
        repeat (2) @(negedge clk);
        check_eq("rst_pc", 32'(pc), 0);
        check_eq("rst_outs", 32'({imem_addr, out_data, out_valid, in_ready, halted}), 0);

        // Test 1: LOADI/LOADI/ADD/OUT, latency and single-cycle out_valid
        imem[0] = ins(4'h1, 4'h2, 4'h3, 4'h1);
        imem[1] = ins(4'h1, 4'h0, 4'h5, 4'h2);
        imem[2] = ins(4'h4, 4'h1, 4'h2, 4'h3);
        imem[3] = ins(4'hF, 4'h3, 4'h0, 4'h0);
        exp_q.push_back(8'h28);
        start_prog();
        check_eq("t1_not_halted", 32'(halted), 0);
        run_prog(cyc);
        check_eq("t1_cycles", cyc, 19);
        check_eq("t1_pc", 32'(pc), 5);
        check_eq("t1_valid_cycles", valid_cycles, 1);
        check_eq("t1_q_empty", exp_q.size(), 0);

        // Test 2: ALU wrap, logic ops, RD==RA, unused opcode as NOP
        rst = 1'b1;
        clear_mem();
        imem[0]  = ins(4'h1, 4'hF, 4'hF, 4'h1);
        imem[1]  = ins(4'h1, 4'h0, 4'h2, 4'h2);
        imem[2]  = ins(4'h4, 4'h1, 4'h2, 4'h4);
        imem[3]  = ins(4'h5, 4'h2, 4'h1, 4'h5);
        imem[4]  = ins(4'hF, 4'h4, 4'h0, 4'h0);
        imem[5]  = ins(4'hF, 4'h5, 4'h0, 4'h0);
        imem[6]  = ins(4'h3, 4'h1, 4'h2, 4'h6);
        imem[7]  = ins(4'hF, 4'h6, 4'h0, 4'h0);
        imem[8]  = ins(4'h6, 4'h1, 4'h2, 4'h7);
        imem[9]  = ins(4'hF, 4'h7, 4'h0, 4'h0);
        imem[10] = ins(4'h7, 4'h1, 4'h2, 4'h8);
        imem[11] = ins(4'hF, 4'h8, 4'h0, 4'h0);
        imem[12] = ins(4'h5, 4'h1, 4'h2, 4'h1);
        imem[13] = ins(4'hF, 4'h1, 4'h0, 4'h0);
        imem[14] = ins(4'h2, 4'hF, 4'hF, 4'h1);
        imem[15] = ins(4'hF, 4'h1, 4'h0, 4'h0);
        a = 8'hFF;
        b = 8'h02;
        exp_q.push_back(a + b);
        exp_q.push_back(b - a);
        exp_q.push_back(a & b);
        exp_q.push_back(a | b);
        exp_q.push_back(a ^ b);
        exp_q.push_back(a - b);
        exp_q.push_back(a - b);
        start_prog();
        run_prog(cyc);
        check_eq("t2_pc", 32'(pc), 17);
        check_eq("t2_q_empty", exp_q.size(), 0);

        // Test 3: BRALZ / BRAZ taken and not taken
        rst = 1'b1;
        clear_mem();
        imem[0]  = ins(4'h1, 4'h0, 4'h1, 4'h6);
        imem[1]  = ins(4'hB, 4'h6, 4'h9, 4'h0);
        imem[2]  = ins(4'h1, 4'h1, 4'h1, 4'h8);
        imem[3]  = ins(4'hF, 4'h8, 4'h0, 4'h0);
        imem[4]  = ins(4'h1, 4'h0, 4'h0, 4'h6);
        imem[5]  = ins(4'hB, 4'h6, 4'h9, 4'h0);
        imem[6]  = ins(4'h1, 4'hE, 4'hE, 4'h8);
        imem[7]  = ins(4'hF, 4'h8, 4'h0, 4'h0);
        imem[9]  = ins(4'h1, 4'h9, 4'h9, 4'h8);
        imem[10] = ins(4'hF, 4'h8, 4'h0, 4'h0);
        imem[11] = ins(4'h1, 4'h1, 4'h0, 4'hA);
        imem[12] = ins(4'h9, 4'h8, 4'hA, 4'h0);
        imem[13] = ins(4'hF, 4'h8, 4'h0, 4'h0);
        imem[14] = ins(4'h9, 4'h6, 4'hA, 4'h0);
        imem[15] = ins(4'hF, 4'hA, 4'h0, 4'h0);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h99);
        exp_q.push_back(8'h99);
        start_prog();
        run_prog(cyc);
        check_eq("t3_pc", 32'(pc), 17);
        check_eq("t3_q_empty", exp_q.size(), 0);

        // Test 4: CALL / BRA return, then frozen PC while halted
        rst = 1'b1;
        clear_mem();
        imem[0] = ins(4'h1, 4'h4, 4'h2, 4'h9);
        imem[1] = ins(4'h0, 4'h0, 4'h0, 4'h0);
        imem[2] = ins(4'hC, 4'h0, 4'h4, 4'h7);
        imem[4] = ins(4'hF, 4'h7, 4'h0, 4'h0);
        imem[5] = ins(4'h8, 4'h0, 4'h7, 4'h0);
        exp_q.push_back(8'h03);
        start_prog();
        run_prog(cyc);
        check_eq("t4_cycles", cyc, 21);
        check_eq("t4_q_empty", exp_q.size(), 0);
        repeat (10) begin
            @(negedge clk);
            check_eq("t4_halt_frozen", 32'({pc, imem_addr, halted}), 32'({8'd4, 8'd4, 1'b1}));
        end

        // Test 5: IN with delayed valid, OUT with delayed ready
        rst = 1'b1;
        clear_mem();
        imem[0] = ins(4'hD, 4'h0, 4'h0, 4'h3);
        imem[1] = ins(4'hF, 4'h3, 4'h0, 4'h0);
        exp_q.push_back(8'h5A);
        out_ready = 1'b0;
        start_prog();
        fork
            run_prog(cyc);
            in_out_driver();
        join
        check_eq("t5_in_once", in_hs, 1);
        check_eq("t5_valid_cycles", valid_cycles, 4);
        check_eq("t5_out_retained", 32'(out_data), 32'h5A);
        check_eq("t5_pc", 32'(pc), 3);
        check_eq("t5_q_empty", exp_q.size(), 0);
        out_ready = 1'b1;

        // Test 6: reset during EXEC of ADD aborts it; restart from address 0
        rst = 1'b1;
        clear_mem();
        imem[0] = ins(4'h1, 4'h2, 4'h3, 4'h1);
        imem[1] = ins(4'h1, 4'h0, 4'h5, 4'h2);
        imem[2] = ins(4'h4, 4'h1, 4'h2, 4'h3);
        imem[3] = ins(4'hF, 4'h3, 4'h0, 4'h0);
        start_prog();
        n = 0;
        while (pc != 8'd3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check_eq("t6_reach_exec", 32'(pc), 3);
        rst = 1'b1;
        #1;
        check_eq("t6_rst_pc", 32'(pc), 0);
        check_eq("t6_rst_outs", 32'({imem_addr, out_data, out_valid, in_ready, halted}), 0);
        clear_mem();
        imem[0] = ins(4'hF, 4'h3, 4'h0, 4'h0);
        imem[1] = ins(4'hF, 4'h1, 4'h0, 4'h0);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        start_prog();
        run_prog(cyc);
        check_eq("t6_pc", 32'(pc), 3);
        check_eq("t6_q_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
